// File: rtl/mem_responder_if.sv
// Cache-to-memory request/response bus for mem_responder.
// The master side issues commands; the slave side answers with tags and load data.
interface mem_responder_if #(
    parameter int unsigned XLEN = 32
);
    logic [1:0]      cache2mem_command;
    logic [XLEN-1:0] cache2mem_addr;
    logic [63:0]     cache2mem_data;
    logic [3:0]      mem2cache_response;
    logic [63:0]     mem2cache_data;
    logic [3:0]      mem2cache_tag;

    modport master (
        output cache2mem_command, cache2mem_addr, cache2mem_data,
        input  mem2cache_response, mem2cache_data, mem2cache_tag
    );

    modport slave (
        input  cache2mem_command, cache2mem_addr, cache2mem_data,
        output mem2cache_response, mem2cache_data, mem2cache_tag
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency tagged memory model: 15 tags, in-order completion FIFO, 64-bit word storage.
// Define MEM_RESPONDER_BACKPRESSURE_EN to add LFSR-driven pseudo-random request rejection.
module mem_responder #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned MEM_LATENCY = 20,
    parameter int unsigned XLEN        = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_responder_if.slave bus
);
    localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned NTAG      = 15;
    localparam int unsigned PW        = 4;
    localparam logic [1:0]  BUS_LOAD  = 2'd1;
    localparam logic [1:0]  BUS_STORE = 2'd2;
    localparam logic [5:0]  CNT_INIT  = 6'(MEM_LATENCY - 1);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd8;

    logic [63:0]   mem_q [MEM_WORDS];
    logic [NTAG:1] busy_q, busy_d;
    logic [3:0]    fifo_tag_q  [NTAG];
    logic [3:0]    fifo_tag_d  [NTAG];
    logic [63:0]   fifo_data_q [NTAG];
    logic [63:0]   fifo_data_d [NTAG];
    logic [5:0]    fifo_cnt_q  [NTAG];
    logic [5:0]    fifo_cnt_d  [NTAG];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW-1:0] count_q, count_d;
    logic [3:0]    out_tag_q, out_tag_d;
    logic [63:0]   out_data_q, out_data_d;

    logic [3:0]    alloc_tag_c;
    logic          tag_free_c;
    logic          is_req_c;
    logic          is_store_c;
    logic          in_range_c;
    logic          bp_ok_c;
    logic          accept_c;
    logic          retire_c;
    logic [AW-1:0] idx_c;
    logic [63:0]   snap_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NTAG - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef MEM_RESPONDER_BACKPRESSURE_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 8,6,5,4
    always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk) begin
        if (!rst_n) lfsr_q <= 8'hA5;
        else        lfsr_q <= lfsr_d;
    end

    assign bp_ok_c = (lfsr_q[1:0] != 2'b00);
`else
    assign bp_ok_c = 1'b1;
`endif

    // Lowest-numbered free tag
    always_comb begin
        alloc_tag_c = '0;
        tag_free_c  = 1'b0;
        for (int i = NTAG; i >= 1; i--) begin
            if (!busy_q[i]) begin
                alloc_tag_c = 4'(i);
                tag_free_c  = 1'b1;
            end
        end
    end

    assign idx_c      = bus.cache2mem_addr[3 +: AW];
    assign in_range_c = 64'(bus.cache2mem_addr) < MEM_BYTES;
    assign is_store_c = (bus.cache2mem_command == BUS_STORE);
    assign is_req_c   = (bus.cache2mem_command == BUS_LOAD) || is_store_c;
    assign accept_c   = rst_n && is_req_c && tag_free_c && bp_ok_c;
    assign snap_c     = (!is_store_c && in_range_c) ? mem_q[idx_c] : 64'h0;
    assign retire_c   = (count_q != '0) && (fifo_cnt_q[rptr_q] == 6'd0);

    assign bus.mem2cache_response = accept_c ? alloc_tag_c : 4'h0;
    assign bus.mem2cache_tag      = out_tag_q;
    assign bus.mem2cache_data     = out_data_q;

    // Completion FIFO, tag bitmap and broadcast register next-state
    always_comb begin
        busy_d     = busy_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        out_tag_d  = '0;
        out_data_d = '0;
        for (int i = 0; i < NTAG; i++) begin
            fifo_tag_d[i]  = fifo_tag_q[i];
            fifo_data_d[i] = fifo_data_q[i];
            fifo_cnt_d[i]  = (fifo_cnt_q[i] != 6'd0) ? fifo_cnt_q[i] - 6'd1 : 6'd0;
        end
        if (retire_c) begin
            out_tag_d                 = fifo_tag_q[rptr_q];
            out_data_d                = fifo_data_q[rptr_q];
            busy_d[fifo_tag_q[rptr_q]] = 1'b0;
            rptr_d                    = ptr_inc(rptr_q);
        end
        if (accept_c) begin
            busy_d[alloc_tag_c]  = 1'b1;
            fifo_tag_d[wptr_q]   = alloc_tag_c;
            fifo_data_d[wptr_q]  = snap_c;
            fifo_cnt_d[wptr_q]   = CNT_INIT;
            wptr_d               = ptr_inc(wptr_q);
        end
        if (accept_c && !retire_c)      count_d = count_q + PW'(1);
        else if (!accept_c && retire_c) count_d = count_q - PW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            out_tag_q  <= '0;
            out_data_q <= '0;
        end else begin
            busy_q     <= busy_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            out_tag_q  <= out_tag_d;
            out_data_q <= out_data_d;
        end
    end

    // FIFO payload is only meaningful under count_q, so it carries no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NTAG; i++) begin
            fifo_tag_q[i]  <= fifo_tag_d[i];
            fifo_data_q[i] <= fifo_data_d[i];
            fifo_cnt_q[i]  <= fifo_cnt_d[i];
        end
    end

    // Storage survives reset; out-of-range stores are dropped
    always_ff @(posedge clk) begin
        if (accept_c && is_store_c && in_range_c) mem_q[idx_c] <= bus.cache2mem_data;
    end
endmodule
